// File: rtl/clock_pkg.sv
// Shared encodings and limits for the 12-hour timekeeper and its set FSM.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_SET_HOUR = 2'd1,
      ST_SET_MIN  = 2'd2,
      ST_SET_AMPM = 2'd3
   } state_t;

   localparam logic [3:0] HOUR12_MIN = 4'd1;
   localparam logic [3:0] HOUR12_MAX = 4'd12;
   localparam logic [5:0] MIN_MAX    = 6'd59;
   localparam logic [5:0] SEC_MAX    = 6'd59;

endpackage

// File: rtl/clock12_sync_tx_if.sv
// extern12_* bundle carrying the 12-hour time to the 24-hour clock.
interface clock12_sync_tx_if;

   logic       extern12_propagate;
   logic       extern12_isPM;
   logic [3:0] extern12_hours;
   logic [5:0] extern12_minutes;

   modport master (
      output extern12_propagate,
      output extern12_isPM,
      output extern12_hours,
      output extern12_minutes
   );

   modport slave (
      input extern12_propagate,
      input extern12_isPM,
      input extern12_hours,
      input extern12_minutes
   );

endinterface

// File: rtl/mod_updown.sv
// Wrapping up/down counter over MIN..MAX with a synchronous parallel load.
module mod_updown #(
   parameter int MIN     = 0,
   parameter int MAX     = 59,
   parameter int W       = 6,
   parameter int RST_VAL = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         up,
   input  logic         down,
   output logic [W-1:0] value
);

   // up and down together cancel; load beats both
   always_ff @(posedge clk) begin
      if (reset) begin
         value <= W'(RST_VAL);
      end else if (load) begin
         value <= load_val;
      end else if (up && !down) begin
         value <= (value == W'(MAX)) ? W'(MIN) : value + W'(1);
      end else if (down && !up) begin
         value <= (value == W'(MIN)) ? W'(MAX) : value - W'(1);
      end
   end

endmodule

// File: rtl/clock12_sync_tx.sv
// 12-hour timekeeper with a button-driven set FSM feeding the extern12_* bus.
// Optional macro CLOCK12_AUTO_SYNC_EN: also strobe propagate at the top of every hour.
module clock12_sync_tx #(
   parameter int RESET_HOUR = 12,
   parameter bit RESET_PM   = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sec_tick,
   input  logic             setEnable,
   input  logic             pulsed_set,
   input  logic             pulsed_up,
   input  logic             pulsed_down,
   clock12_sync_tx_if.master bus,
   output logic [5:0]       seconds,
   output logic [1:0]       w_current_state,
   output logic [3:0]       edit_hours,
   output logic [5:0]       edit_minutes,
   output logic             edit_isPM
);

   import clock_pkg::*;

   state_t     state;
   state_t     next_state;
   logic       commit;
   logic       edit_load;
   logic       hour_up;
   logic       hour_down;
   logic       min_up;
   logic       min_down;
   logic       ampm_toggle;
   logic       edit_ok;
   logic [3:0] hours;
   logic [5:0] minutes;
   logic       is_pm;
   logic       propagate;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_RUN;
      end else begin
         state <= next_state;
      end
   end

   // pulsed_set suppresses edits in the same cycle; dropping setEnable aborts
   always_comb begin
      next_state  = state;
      commit      = 1'b0;
      edit_load   = 1'b0;
      edit_ok     = setEnable && !pulsed_set;
      hour_up     = 1'b0;
      hour_down   = 1'b0;
      min_up      = 1'b0;
      min_down    = 1'b0;
      ampm_toggle = 1'b0;
      case (state)
         ST_RUN: begin
            if (setEnable && pulsed_set) begin
               next_state = ST_SET_HOUR;
               edit_load  = 1'b1;
            end
         end
         ST_SET_HOUR: begin
            hour_up   = edit_ok && pulsed_up;
            hour_down = edit_ok && pulsed_down;
            if (!setEnable)      next_state = ST_RUN;
            else if (pulsed_set) next_state = ST_SET_MIN;
         end
         ST_SET_MIN: begin
            min_up   = edit_ok && pulsed_up;
            min_down = edit_ok && pulsed_down;
            if (!setEnable)      next_state = ST_RUN;
            else if (pulsed_set) next_state = ST_SET_AMPM;
         end
         ST_SET_AMPM: begin
            ampm_toggle = edit_ok && (pulsed_up ^ pulsed_down);
            if (!setEnable) begin
               next_state = ST_RUN;
            end else if (pulsed_set) begin
               next_state = ST_RUN;
               commit     = 1'b1;
            end
         end
         default: next_state = ST_RUN;
      endcase
   end

   mod_updown #(
      .MIN(int'(HOUR12_MIN)), .MAX(int'(HOUR12_MAX)), .W(4), .RST_VAL(RESET_HOUR)
   ) u_edit_hours (
      .clk(clk), .reset(reset), .load(edit_load), .load_val(hours),
      .up(hour_up), .down(hour_down), .value(edit_hours)
   );

   mod_updown #(
      .MIN(0), .MAX(int'(MIN_MAX)), .W(6), .RST_VAL(0)
   ) u_edit_minutes (
      .clk(clk), .reset(reset), .load(edit_load), .load_val(minutes),
      .up(min_up), .down(min_down), .value(edit_minutes)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         edit_isPM <= RESET_PM;
      end else if (edit_load) begin
         edit_isPM <= is_pm;
      end else if (ampm_toggle) begin
         edit_isPM <= ~edit_isPM;
      end
   end

   // A commit overrides the second tick of the same cycle, so at most one strobe
   always_ff @(posedge clk) begin
      if (reset) begin
         hours     <= 4'(RESET_HOUR);
         minutes   <= 6'd0;
         seconds   <= 6'd0;
         is_pm     <= RESET_PM;
         propagate <= 1'b0;
      end else begin
         propagate <= 1'b0;
         if (commit) begin
            hours     <= edit_hours;
            minutes   <= edit_minutes;
            is_pm     <= edit_isPM;
            seconds   <= 6'd0;
            propagate <= 1'b1;
         end else if (sec_tick) begin
            if (seconds == SEC_MAX) begin
               seconds <= 6'd0;
               if (minutes == MIN_MAX) begin
                  minutes <= 6'd0;
`ifdef CLOCK12_AUTO_SYNC_EN
                  propagate <= 1'b1;
`endif
                  if (hours == HOUR12_MAX) begin
                     hours <= HOUR12_MIN;
                  end else begin
                     hours <= hours + 4'd1;
                     if (hours == HOUR12_MAX - 4'd1) begin
                        is_pm <= ~is_pm;
                     end
                  end
               end else begin
                  minutes <= minutes + 6'd1;
               end
            end else begin
               seconds <= seconds + 6'd1;
            end
         end
      end
   end

   assign bus.extern12_propagate = propagate;
   assign bus.extern12_isPM      = is_pm;
   assign bus.extern12_hours     = hours;
   assign bus.extern12_minutes   = minutes;
   assign w_current_state        = state;

endmodule

// File: tb/tb_clock12_sync_tx.sv
// Directed bench for clock12_sync_tx; propagate strobes are scored against a queue of expected times.
module tb_clock12_sync_tx;

   import clock_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sec_tick = 1'b0;
   logic       setEnable = 1'b0;
   logic       pulsed_set = 1'b0;
   logic       pulsed_up = 1'b0;
   logic       pulsed_down = 1'b0;
   logic [5:0] seconds;
   logic [1:0] w_current_state;
   logic [3:0] edit_hours;
   logic [5:0] edit_minutes;
   logic       edit_isPM;

   int checks = 0;
   int errors = 0;
   logic [10:0] expQ[$];

   clock12_sync_tx_if bus();

   clock12_sync_tx dut (
      .clk(clk), .reset(reset), .sec_tick(sec_tick), .setEnable(setEnable),
      .pulsed_set(pulsed_set), .pulsed_up(pulsed_up), .pulsed_down(pulsed_down),
      .bus(bus), .seconds(seconds), .w_current_state(w_current_state),
      .edit_hours(edit_hours), .edit_minutes(edit_minutes), .edit_isPM(edit_isPM)
   );

   always #5 clk = ~clk;

   // Monitor: every propagate cycle must match the oldest expected commit/sync
   always @(negedge clk) begin
      if (!reset && bus.extern12_propagate) begin
         checks++;
         if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL propagate_unexpected got %0d:%0d pm=%0d required none",
                     bus.extern12_hours, bus.extern12_minutes, bus.extern12_isPM);
         end else begin
            logic [10:0] exp;
            exp = expQ.pop_front();
            if ({bus.extern12_hours, bus.extern12_minutes, bus.extern12_isPM} !== exp) begin
               errors++;
               $display("[TB] FAIL propagate_value got %0d:%0d pm=%0d required %0d:%0d pm=%0d",
                        bus.extern12_hours, bus.extern12_minutes, bus.extern12_isPM,
                        exp[10:7], exp[6:1], exp[0]);
            end
         end
      end
   end

   task automatic applyStimulus(input logic s, input logic u, input logic d, input logic t);
      pulsed_set  = s;
      pulsed_up   = u;
      pulsed_down = d;
      sec_tick    = t;
      @(posedge clk);
      #1;
      pulsed_set  = 1'b0;
      pulsed_up   = 1'b0;
      pulsed_down = 1'b0;
      sec_tick    = 1'b0;
   endtask

   task automatic runTicks(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s got %0d required %0d", name, actual, expected);
      end
   endtask

   task automatic checkTime(input string name, input int h, input int m, input int s, input int pm);
      checkOutput(name, {bus.extern12_hours, bus.extern12_minutes, seconds, bus.extern12_isPM},
                  {h[3:0], m[5:0], s[5:0], pm[0]});
   endtask

   task automatic pushExp(input int h, input int m, input int pm);
      expQ.push_back({h[3:0], m[5:0], pm[0]});
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got timeout required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset_state", w_current_state, ST_RUN);
      checkTime("reset_time", 12, 0, 0, 0);
      checkOutput("reset_edit", {edit_hours, edit_minutes, edit_isPM}, {4'd12, 6'd0, 1'b0});

      runTicks(3);
      checkTime("three_ticks", 12, 0, 3, 0);

      // Set to 10:59 PM
      setEnable = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("enter_set_hour", w_current_state, ST_SET_HOUR);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("edit_hour_down2", edit_hours, 10);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("edit_min_wrap", edit_minutes, 59);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("enter_set_ampm", w_current_state, ST_SET_AMPM);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("edit_ampm_toggle", edit_isPM, 1);
      pushExp(10, 59, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("commit_state", w_current_state, ST_RUN);
      checkTime("commit_time", 10, 59, 0, 1);

      // Same-cycle set+up, up+down together, then abort with a tick
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("set_beats_up_state", w_current_state, ST_SET_MIN);
      checkOutput("set_beats_up_hour", edit_hours, 10);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("up_down_together", edit_minutes, 59);
      setEnable = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("abort_state", w_current_state, ST_RUN);
      checkTime("abort_time", 10, 59, 1, 1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("disabled_buttons_state", w_current_state, ST_RUN);
      checkOutput("disabled_buttons_edit", edit_hours, 10);

      // Preload 11:59 AM, roll to 12:00:00 PM
      setEnable = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      pushExp(11, 59, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkTime("preload_am", 11, 59, 0, 0);
      runTicks(58);
      checkTime("am_5958", 11, 59, 58, 0);
`ifdef CLOCK12_AUTO_SYNC_EN
      pushExp(12, 0, 1);
`endif
      runTicks(2);
      checkTime("am_to_pm_noon", 12, 0, 0, 1);

      // Preload 11:59 PM, roll to 12:00:00 AM
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("hour_wrap_down", edit_hours, 11);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      pushExp(11, 59, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkTime("preload_pm", 11, 59, 0, 1);
      runTicks(59);
      checkTime("pm_5959", 11, 59, 59, 1);
`ifdef CLOCK12_AUTO_SYNC_EN
      pushExp(12, 0, 0);
`endif
      runTicks(1);
      checkTime("pm_to_midnight", 12, 0, 0, 0);

      // 1:59:59 -> 2:00:00 (top-of-hour sync only with the macro)
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("hour_wrap_up", edit_hours, 1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      pushExp(1, 59, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      runTicks(59);
      checkTime("one_5959", 1, 59, 59, 0);
`ifdef CLOCK12_AUTO_SYNC_EN
      pushExp(2, 0, 0);
`endif
      runTicks(1);
      checkTime("two_oclock", 2, 0, 0, 0);

      // Commit and tick in the same cycle: commit wins, seconds cleared
      runTicks(5);
      checkTime("two_0005", 2, 0, 5, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      pushExp(2, 0, 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      checkTime("commit_beats_tick", 2, 0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("pending_propagates", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
